// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bundle for serial_subtractor
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [CW-1:0]    cnt;
    logic             br, d, br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif
    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ br;
        br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.diff   <= '0;
            bus.borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            bus.ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sr     <= bus.a;
                    b_sr     <= bus.b;
                    r_sr     <= '0;
                    cnt      <= '0;
                    br       <= 1'b0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb    <= bus.a[WIDTH-1];
                    b_msb    <= bus.b[WIDTH-1];
`endif
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= {d, r_sr[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // Only the final bit publishes; diff/borrow never show partial results.
                    if (cnt == LAST) begin
                        bus.diff   <= {d, r_sr[WIDTH-1:1]};
                        bus.borrow <= br_next;
                        bus.done   <= 1'b1;
                        state      <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        bus.ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench for serial_subtractor
// Reference model is plain modular/signed arithmetic; honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;
    localparam int WIDTH = 8;
    localparam int MOD = 1 << WIDTH;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    logic [WIDTH-1:0] exp_diff = '0;
    logic             exp_borrow = 1'b0;
    logic             exp_ovf = 1'b0;
    serial_subtractor_if #(.WIDTH(WIDTH)) bus_if ();
    serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus_if));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int sval(input logic [WIDTH-1:0] v);
        return v >= MOD / 2 ? int'(v) - MOD : int'(v);
    endfunction
    task automatic check_result(input string tag);
        check({tag, "_diff"}, 32'(bus_if.diff), 32'(exp_diff));
        check({tag, "_borrow"}, 32'(bus_if.borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(bus_if.ovf), 32'(exp_ovf));
`endif
    endtask
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int sd;
        exp_diff   = WIDTH'((int'(a) - int'(b) + MOD) % MOD);
        exp_borrow = a < b;
        sd         = sval(a) - sval(b);
        exp_ovf    = sd >= MOD / 2 || sd < -(MOD / 2);
    endtask
    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit scramble);
        int n = -1;
        int bc = 0;
        int dc = 0;
        logic [WIDTH-1:0] prev = exp_diff;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a = a;
        bus_if.b = b;
        model(a, b);
        @(negedge clk);
        for (int i = 1; i <= WIDTH + 4; i++) begin
            if (bus_if.busy) bc++;
            if (bus_if.done) begin
                dc++;
                if (n < 0) begin
                    n = i - 1;
                    check_result("op");
                end
            end else if (n < 0) begin
                check("hold_diff", 32'(bus_if.diff), 32'(prev));
            end
            bus_if.start = scramble && n < 0;
            bus_if.a = WIDTH'($urandom);
            bus_if.b = WIDTH'($urandom);
            @(negedge clk);
        end
        check("latency", n, WIDTH);
        check("busy_cycles", bc, WIDTH + 1);
        check("done_pulses", dc, 1);
        check("idle_busy", 32'(bus_if.busy), 0);
    endtask
    initial begin
        logic [WIDTH-1:0] ra, rb;
        int last, w;
        bus_if.start = 1'b0;
        bus_if.a = '0;
        bus_if.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 0);
        check("rst_done", 32'(bus_if.done), 0);
        check_result("rst");
        rst = 1'b0;
        op(8'h05, 8'h03, 0);
        op(8'h03, 8'h05, 0);
        op(8'h00, 8'h00, 0);
        op(8'hFF, 8'hFF, 0);
        op(8'h80, 8'h01, 0);
        op(8'h7F, 8'hFF, 0);
        op(8'h05, 8'h03, 0);
        op(8'h10, 8'h01, 1);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a = 8'h80;
        bus_if.b = 8'h01;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_diff = '0;
        exp_borrow = 1'b0;
        exp_ovf = 1'b0;
        check("abort_busy", 32'(bus_if.busy), 0);
        check_result("abort");
        w = 0;
        repeat (WIDTH + 3) begin
            @(negedge clk);
            w += int'(bus_if.done);
        end
        check("abort_no_done", w, 0);
        op(8'h80, 8'h01, 0);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a = 8'h01;
        bus_if.b = 8'h02;
        model(8'h01, 8'h02);
        last = -1;
        for (int p = 0; p < 3; p++) begin
            w = 0;
            @(negedge clk);
            while (!bus_if.done && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!bus_if.done) begin
                check("b2b_timeout", 0, 1);
                break;
            end
            check_result("b2b");
            if (last >= 0) check("b2b_period", cyc - last, WIDTH + 2);
            last = cyc;
        end
        bus_if.start = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
        for (int r = 0; r < 20; r++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            op(ra, rb, r[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
